// File: rtl/bram_port_hs.sv
// Purpose : parametrised block-RAM data port for the data memory path, with valid/ready
//           request and response handshakes, byte write enables and out-of-range errors.
// Latency : response READ_LATENCY (1 or 2) cycles after accept; one request per cycle sustained.
// Backpr. : req_ready drops when READ_LATENCY+1 requests are outstanding; responses are held
//           in an output buffer while resp_ready is low, never dropped or duplicated.
// Ports   : clk/resetn (sync, active-low); req_valid/req_ready/req_addr/req_wstrb/req_wdata
//           request side; resp_valid/resp_ready/resp_rdata/resp_err response side.
module bram_port_hs #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IW    = $clog2(DEPTH);
  localparam int WBITS = ADDR_W - OFF;
  localparam int BUF   = READ_LATENCY + 1;
  localparam int CW    = $clog2(BUF + 1);
  localparam int PW    = $clog2(BUF);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic          oor;
  logic [IW-1:0] widx;
  logic          accept;
  logic          unused_addr;

  assign widx = req_addr[OFF +: IW];
  // Byte-offset bits are ignored; reduce them so every input bit is consumed.
  assign unused_addr = ^req_addr;

  // Out of range means any word-index bit above the array index is set.
  if (WBITS > IW) begin : g_oor
    assign oor = |req_addr[ADDR_W-1:OFF+IW];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  // The resetn term keeps a request offered during the reset cycle from touching memory.
  assign accept = req_valid && req_ready && resetn;

  // ---------------------------------------------------------------------------
  // Outstanding-request accounting (accepted minus delivered)
  // ---------------------------------------------------------------------------
  logic          ready_q;
  logic [CW-1:0] cnt;
  logic          deliver;

  assign req_ready = ready_q && (cnt < CW'(BUF));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      cnt     <= '0;
    end else begin
      ready_q <= 1'b1;
      cnt     <= cnt + CW'(accept) - CW'(deliver);
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array: read-first synchronous port with byte enables (BRAM template).
  // The old word is always captured; write-first data is rebuilt from it one stage
  // later, so the array itself stays a plain read-first RAM in both modes.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q <= mem[widx];
      if (!oor) begin
        for (int i = 0; i < NB; i++) begin
          if (req_wstrb[i]) mem[widx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: side information travelling with the RAM read
  // ---------------------------------------------------------------------------
  logic              s1_vld;
  logic              s1_err;
  logic [NB-1:0]     s1_wstrb;
  logic [DATA_W-1:0] s1_wdata;
  logic [DATA_W-1:0] s1_merged;
  logic [DATA_W-1:0] s1_dat;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_vld   <= 1'b0;
      s1_err   <= 1'b0;
      s1_wstrb <= '0;
      s1_wdata <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_err   <= oor;
        s1_wstrb <= req_wstrb;
        s1_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    s1_merged = rd_q;
    for (int i = 0; i < NB; i++) begin
      if (s1_wstrb[i]) s1_merged[8*i +: 8] = s1_wdata[8*i +: 8];
    end
    if (s1_err)                s1_dat = '0;
    else if (WRITE_MODE == 1)  s1_dat = s1_merged;
    else                       s1_dat = rd_q;
  end

  // ---------------------------------------------------------------------------
  // Optional second pipeline stage
  // ---------------------------------------------------------------------------
  logic              p_vld;
  logic              p_err;
  logic [DATA_W-1:0] p_dat;

  if (READ_LATENCY == 2) begin : g_lat2
    logic              s2_vld;
    logic              s2_err;
    logic [DATA_W-1:0] s2_dat;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        s2_vld <= 1'b0;
        s2_err <= 1'b0;
        s2_dat <= '0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_err <= s1_err;
          s2_dat <= s1_dat;
        end
      end
    end

    assign p_vld = s2_vld;
    assign p_err = s2_err;
    assign p_dat = s2_dat;
  end else begin : g_lat1
    assign p_vld = s1_vld;
    assign p_err = s1_err;
    assign p_dat = s1_dat;
  end

  // ---------------------------------------------------------------------------
  // Output buffer. The pipeline never stalls: cnt caps in-flight requests at BUF,
  // so a response leaving the pipeline always finds room here. With the buffer
  // empty the pipeline output bypasses straight to the response port; if it is
  // not taken it is parked in the buffer and re-presented unchanged next cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] buf_dat [BUF];
  logic              buf_err [BUF];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     bcnt;
  logic              buf_empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_dat;
  logic              head_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF - 1)) ? '0 : p + 1'b1;
  endfunction

  assign buf_empty = (bcnt == '0);
  assign resp_valid = !buf_empty || p_vld;
  assign head_dat   = buf_empty ? p_dat : buf_dat[rptr];
  assign head_err   = buf_empty ? p_err : buf_err[rptr];
  assign resp_rdata = resp_valid ? head_dat : '0;
  assign resp_err   = resp_valid ? head_err : 1'b0;

  assign deliver = resp_valid && resp_ready;
  assign pop     = !buf_empty && resp_ready;
  assign push    = p_vld && !(buf_empty && resp_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      buf_dat[wptr] <= p_dat;
      buf_err[wptr] <= p_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      bcnt <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      bcnt <= bcnt + CW'(push) - CW'(pop);
    end
  end

endmodule
